pc_branch_unit: RTL

- Fetch-side PC register and branch/jump resolution unit, directly downstream of the ALU in the RV32I core.
- Consumes the ALU result F and zero flag z (ALU run in subtract mode, s=1, for BEQ/BNE) plus decoded control from EX.
- Produces the next fetch PC, the link address, and a multi-cycle pipeline flush after any taken control transfer.

---
 rtl/pc_branch_unit.sv | 78 +++++++
 1 files changed

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - fetch PC register with branch/jump resolution and pipeline flush
module pc_branch_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [31:0] imm,
   input  logic        is_beq,
   input  logic        is_bne,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic [31:0] alu_f,
   input  logic        alu_z,
   output logic [31:0] pc_out,
   output logic [31:0] link_addr,
   output logic        redirect,
   output logic        flush,
   output logic        misalign_err
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

   logic [2:0]  flush_cnt;
   logic        ctrl_taken;
   logic [31:0] target;
   logic        take;
   logic        aligned;

   // Priority chain resolves illegal multi-hot controls as jalr > jal > beq > bne.
   always_comb begin
      ctrl_taken = 1'b0;
      target     = ex_pc + imm;
      if (is_jalr) begin
         ctrl_taken = 1'b1;
         target     = alu_f & ~32'h1;
      end else if (is_jal) begin
         ctrl_taken = 1'b1;
      end else if (is_beq) begin
         ctrl_taken = alu_z;
      end else if (is_bne) begin
         ctrl_taken = ~alu_z;
      end
   end

   // Anything in EX while flushing is wrong-path and must not redirect.
   assign flush     = (flush_cnt != 3'd0);
   assign take      = ex_valid & ~flush & ctrl_taken;
   assign aligned   = (target[1:0] == 2'b00);
   assign link_addr = ex_pc + 32'd4;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_out       <= RESET_PC;
         redirect     <= 1'b0;
         flush_cnt    <= 3'd0;
         misalign_err <= 1'b0;
      end else begin
         redirect <= 1'b0;
         if (take && aligned) begin
            pc_out    <= target;
            redirect  <= 1'b1;
            flush_cnt <= FLUSH_LOAD;
         end else begin
            if (!stall)
               pc_out <= pc_out + 32'd4;
            if (flush_cnt != 3'd0)
               flush_cnt <= flush_cnt - 3'd1;
         end
         if (take && !aligned)
            misalign_err <= 1'b1;
      end
   end

endmodule
